benes_out_checker: RTL and testbench



---
 rtl/benes_chk_pkg.sv | 25 ++
 rtl/benes_chk_lane.sv | 41 ++++
 rtl/benes_out_checker.sv | 201 ++++++++++++++++++++
 tb/tb_benes_out_checker.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/benes_chk_pkg.sv
// Shared types and the per-source step rule for the Benes output checker.
package benes_chk_pkg;

    localparam int DEF_SIZE = 8;

    typedef logic [$clog2(DEF_SIZE)-1:0] lane_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PCHK,
        ST_SETTLE,
        ST_LOCK,
        ST_CHECK,
        ST_DONE
    } chk_state_t;

    // Lower half of the sources count up by s+1, upper half count down by s-SIZE/2+1.
    function automatic int step_of(input int src, input int size);
        if (src < size / 2)
            return src + 1;
        else
            return -(src - size / 2 + 1);
    endfunction

endpackage

// File: rtl/benes_chk_lane.sv
// One output lane: remembers the previous sample and predicts the next one
// from the step of the source lane routed here.
// Optional macro BENES_CHK_FIRST_FAIL_EN exposes the prediction for first-fail capture.
module benes_chk_lane
    import benes_chk_pkg::*;
#(
    parameter int SIZE       = 8,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      src,
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic                  lock,
    input  logic                  check,
`ifdef BENES_CHK_FIRST_FAIL_EN
    output logic [DATA_WIDTH-1:0] pred,
`endif
    output logic                  mismatch
);

`ifndef BENES_CHK_FIRST_FAIL_EN
    logic [DATA_WIDTH-1:0] pred;
`endif
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH-1:0] step;

    assign step     = DATA_WIDTH'(step_of(int'(src), SIZE));
    assign pred     = prev + step;
    assign mismatch = check && (sample != pred);

    // Track the live sample so a single slip costs one error, not a lasting offset.
    always_ff @(posedge clk) begin
        if (rst)
            prev <= '0;
        else if (lock || check)
            prev <= sample;
    end

endmodule

// File: rtl/benes_out_checker.sv
// Receive-side checker for the Benes test network outputs.
// Optional macro BENES_CHK_FIRST_FAIL_EN adds first-mismatch capture ports.
//
// state  | meaning
// IDLE   | waiting for i_start
// PCHK   | checking the latched permutation is a bijection
// SETTLE | ignoring ports while the network pipeline flushes
// LOCK   | loading every lane's previous sample
// CHECK  | comparing each lane against its prediction
// DONE   | verdict valid, waiting for restart
module benes_out_checker
    import benes_chk_pkg::*;
#(
    parameter int SIZE       = 8,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = $clog2(SIZE),
    parameter int SETTLE_CYC = 16,
    parameter int CHECK_CYC  = 256,
    parameter int ERR_W      = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_start,
    input  logic [SIZE-1:0][IDX_W-1:0]           i_perm,
    input  logic [SIZE-1:0][DATA_WIDTH-1:0]      i_port,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_pass,
    output logic                                 o_perm_err,
    output logic [SIZE-1:0]                      o_err_mask,
`ifdef BENES_CHK_FIRST_FAIL_EN
    output logic                                 o_ff_valid,
    output logic [IDX_W-1:0]                     o_ff_lane,
    output logic [DATA_WIDTH-1:0]                o_ff_exp,
    output logic [DATA_WIDTH-1:0]                o_ff_act,
    output logic [$clog2(CHECK_CYC)-1:0]         o_ff_cycle,
`endif
    output logic [ERR_W-1:0]                     o_err_cnt
);

    localparam int TMR_W = $clog2((CHECK_CYC > SETTLE_CYC) ? CHECK_CYC : SETTLE_CYC);
    localparam int POP_W = $clog2(SIZE + 1);
    localparam int SUM_W = ERR_W + POP_W;
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    chk_state_t                 state;
    logic [TMR_W-1:0]           tmr;
    logic [SIZE-1:0][IDX_W-1:0] perm_q;
    logic [SIZE-1:0]            mm;
    logic [SIZE-1:0]            used;
    logic                       dup;
    logic [POP_W-1:0]           pop;
    logic [SUM_W-1:0]           sum;
    logic [ERR_W-1:0]           cnt_nxt;
    logic                       accept_start;

`ifdef BENES_CHK_FIRST_FAIL_EN
    logic [SIZE-1:0][DATA_WIDTH-1:0] lane_pred;
`endif

    assign accept_start = i_start && (state == ST_IDLE || state == ST_DONE);

    for (genvar j = 0; j < SIZE; j++) begin : g_lane
        benes_chk_lane #(
            .SIZE       (SIZE),
            .DATA_WIDTH (DATA_WIDTH),
            .IDX_W      (IDX_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .src      (perm_q[j]),
            .sample   (i_port[j]),
            .lock     (state == ST_LOCK),
            .check    (state == ST_CHECK),
`ifdef BENES_CHK_FIRST_FAIL_EN
            .pred     (lane_pred[j]),
`endif
            .mismatch (mm[j])
        );
    end

    // Source-usage bitmap: any source seen twice means the permutation is not a bijection.
    always_comb begin
        used = '0;
        dup  = 1'b0;
        for (int j = 0; j < SIZE; j++) begin
            if (used[perm_q[j]])
                dup = 1'b1;
            used[perm_q[j]] = 1'b1;
        end
    end

    // Popcount of this cycle's mismatches folded into a saturating total.
    always_comb begin
        pop = '0;
        for (int j = 0; j < SIZE; j++)
            pop = pop + POP_W'(mm[j]);
        sum     = SUM_W'(o_err_cnt) + SUM_W'(pop);
        cnt_nxt = (sum > SUM_W'(ERR_MAX)) ? ERR_MAX : sum[ERR_W-1:0];
    end

    // Run sequencing and all registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            tmr        <= '0;
            perm_q     <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_pass     <= 1'b0;
            o_perm_err <= 1'b0;
            o_err_mask <= '0;
            o_err_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        perm_q     <= i_perm;
                        o_err_mask <= '0;
                        o_err_cnt  <= '0;
                        o_pass     <= 1'b0;
                        o_perm_err <= 1'b0;
                        o_busy     <= 1'b1;
                        o_done     <= 1'b0;
                        state      <= ST_PCHK;
                    end
                end
                ST_PCHK: begin
                    if (dup) begin
                        o_perm_err <= 1'b1;
                        o_pass     <= 1'b0;
                        o_busy     <= 1'b0;
                        o_done     <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        tmr   <= TMR_W'(SETTLE_CYC - 1);
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (tmr == '0)
                        state <= ST_LOCK;
                    else
                        tmr <= tmr - 1'b1;
                end
                ST_LOCK: begin
                    tmr   <= TMR_W'(CHECK_CYC - 1);
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    o_err_mask <= o_err_mask | mm;
                    o_err_cnt  <= cnt_nxt;
                    if (tmr == '0) begin
                        o_pass <= ((o_err_mask | mm) == '0) && !o_perm_err;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef BENES_CHK_FIRST_FAIL_EN
    localparam int CYC_W = $clog2(CHECK_CYC);

    logic [IDX_W-1:0] ff_lane_nxt;

    // Lowest mismatching lane: scan downward so the last hit is the smallest index.
    always_comb begin
        ff_lane_nxt = '0;
        for (int j = SIZE - 1; j >= 0; j--)
            if (mm[j])
                ff_lane_nxt = IDX_W'(j);
    end

    // Capture the first mismatch of a run; cleared by start and reset.
    always_ff @(posedge clk) begin
        if (rst || accept_start) begin
            o_ff_valid <= 1'b0;
            o_ff_lane  <= '0;
            o_ff_exp   <= '0;
            o_ff_act   <= '0;
            o_ff_cycle <= '0;
        end else if (state == ST_CHECK && (|mm) && !o_ff_valid) begin
            o_ff_valid <= 1'b1;
            o_ff_lane  <= ff_lane_nxt;
            o_ff_exp   <= lane_pred[ff_lane_nxt];
            o_ff_act   <= i_port[ff_lane_nxt];
            o_ff_cycle <= CYC_W'(TMR_W'(CHECK_CYC - 1) - tmr);
        end
    end
`else
    logic unused_start;
    assign unused_start = accept_start;
`endif

endmodule

// File: tb/tb_benes_out_checker.sv
// Randomised bench for benes_out_checker with a cycle-indexed reference model.
module tb_benes_out_checker;

    localparam int SIZE = 8;
    localparam int DW   = 8;
    localparam int IW   = 3;
    localparam int CC   = 256;
    localparam int CW   = 8;
    localparam int NK   = 275;   // start edge 0 .. DONE edge 274
    localparam int LOCK_K  = 18;
    localparam int CHK0_K  = 19;

    typedef logic [SIZE-1:0][IW-1:0] perm_vec_t;

    logic clk = 1'b0;
    logic rst;
    logic i_start;
    perm_vec_t i_perm;
    logic [SIZE-1:0][DW-1:0] i_port;

    logic o_busy, o_done, o_pass, o_perm_err;
    logic [SIZE-1:0] o_err_mask;
    logic [15:0] o_err_cnt;
    logic o_busy_b, o_done_b, o_pass_b, o_perm_err_b;
    logic [SIZE-1:0] o_err_mask_b;
    logic [3:0] o_err_cnt_b;
`ifdef BENES_CHK_FIRST_FAIL_EN
    logic o_ff_valid, o_ff_valid_b;
    logic [IW-1:0] o_ff_lane, o_ff_lane_b;
    logic [DW-1:0] o_ff_exp, o_ff_act, o_ff_exp_b, o_ff_act_b;
    logic [CW-1:0] o_ff_cycle, o_ff_cycle_b;
`endif

    benes_out_checker dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_perm(i_perm), .i_port(i_port),
        .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_perm_err(o_perm_err),
        .o_err_mask(o_err_mask),
`ifdef BENES_CHK_FIRST_FAIL_EN
        .o_ff_valid(o_ff_valid), .o_ff_lane(o_ff_lane), .o_ff_exp(o_ff_exp),
        .o_ff_act(o_ff_act), .o_ff_cycle(o_ff_cycle),
`endif
        .o_err_cnt(o_err_cnt)
    );

    benes_out_checker #(.ERR_W(4)) dut_sat (
        .clk(clk), .rst(rst), .i_start(i_start), .i_perm(i_perm), .i_port(i_port),
        .o_busy(o_busy_b), .o_done(o_done_b), .o_pass(o_pass_b), .o_perm_err(o_perm_err_b),
        .o_err_mask(o_err_mask_b),
`ifdef BENES_CHK_FIRST_FAIL_EN
        .o_ff_valid(o_ff_valid_b), .o_ff_lane(o_ff_lane_b), .o_ff_exp(o_ff_exp_b),
        .o_ff_act(o_ff_act_b), .o_ff_cycle(o_ff_cycle_b),
`endif
        .o_err_cnt(o_err_cnt_b)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int chk_p [SIZE];
    int route_p [SIZE];
    int base [SIZE];
    logic [DW-1:0] hist [NK][SIZE];

    int         e_cnt;
    logic [7:0] e_mask;
    bit         e_ffv;
    int         e_fflane, e_ffcyc;
    logic [7:0] e_ffexp, e_ffact;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_step(input int s);
        return (s < SIZE / 2) ? s + 1 : (SIZE / 2 - 1) - s;
    endfunction

    function automatic perm_vec_t pack_chk();
        perm_vec_t r;
        for (int j = 0; j < SIZE; j++) r[j] = IW'(chk_p[j]);
        return r;
    endfunction

    task automatic set_identity(output int p [SIZE]);
        for (int j = 0; j < SIZE; j++) p[j] = j;
    endtask

    task automatic set_reverse(output int p [SIZE]);
        for (int j = 0; j < SIZE; j++) p[j] = SIZE - 1 - j;
    endtask

    task automatic set_shuffle(output int p [SIZE]);
        int t, r;
        for (int j = 0; j < SIZE; j++) p[j] = j;
        for (int j = SIZE - 1; j > 0; j--) begin
            r = $urandom_range(j, 0);
            t = p[j]; p[j] = p[r]; p[r] = t;
        end
    endtask

    task automatic random_bases();
        for (int s = 0; s < SIZE; s++) base[s] = int'($urandom_range(255, 0));
    endtask

    // Reference: every lane predicts from its own previous sample using the step of the checked source.
    task automatic model_run();
        logic [7:0] prev [SIZE];
        logic [7:0] pr;
        e_cnt = 0; e_mask = '0; e_ffv = 1'b0;
        e_fflane = 0; e_ffcyc = 0; e_ffexp = '0; e_ffact = '0;
        for (int j = 0; j < SIZE; j++) prev[j] = hist[LOCK_K][j];
        for (int k = CHK0_K; k < NK; k++) begin
            for (int j = 0; j < SIZE; j++) begin
                pr = 8'((int'(prev[j]) + model_step(chk_p[j])) & 255);
                if (hist[k][j] != pr) begin
                    e_cnt++;
                    e_mask[j] = 1'b1;
                    if (!e_ffv) begin
                        e_ffv = 1'b1; e_fflane = j; e_ffcyc = k - CHK0_K;
                        e_ffexp = pr; e_ffact = hist[k][j];
                    end
                end
                prev[j] = hist[k][j];
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_done"}, 32'(o_done), 0);
        check({tag, "_pass"}, 32'(o_pass), 0);
        check({tag, "_perm_err"}, 32'(o_perm_err), 0);
        check({tag, "_mask"}, 32'(o_err_mask), 0);
        check({tag, "_cnt"}, 32'(o_err_cnt), 0);
`ifdef BENES_CHK_FIRST_FAIL_EN
        check({tag, "_ff_valid"}, 32'(o_ff_valid), 0);
        check({tag, "_ff_lane"}, 32'(o_ff_lane), 0);
        check({tag, "_ff_cycle"}, 32'(o_ff_cycle), 0);
`endif
    endtask

    // Drives one run: start at edge 0, source counters with delay d routed by route_p,
    // an optional slip (persistent offset) on one lane, ignored starts, or a reset at rst_k.
    task automatic run_stream(input string name, input int d, input int slip_lane,
                              input int slip_k, input int slip_val, input bit extra_starts,
                              input int rst_k);
        int v;
        for (int k = 0; k < NK; k++) begin
            @(negedge clk);
            i_start = (k == 0) || (extra_starts && (k == 1 || k == 5 || k == LOCK_K || k == 100));
            rst = (k == rst_k);
            if (k == 0) i_perm = pack_chk();
            else        i_perm = perm_vec_t'($urandom);
            for (int j = 0; j < SIZE; j++) begin
                v = base[route_p[j]] + (k - d) * model_step(route_p[j]);
                if (j == slip_lane && k >= slip_k) v = v + slip_val;
                hist[k][j] = 8'(v & 255);
                i_port[j]  = hist[k][j];
            end
            @(posedge clk);
            #1;
            if (k == rst_k) begin
                check_all_zero({name, "_rst"});
                check({name, "_rst_b_cnt"}, 32'(o_err_cnt_b), 0);
                @(negedge clk);
                rst = 1'b0;
                i_start = 1'b0;
                return;
            end
            if (k == 1) begin
                check({name, "_busy_early"}, 32'(o_busy), 1);
                check({name, "_done_early"}, 32'(o_done), 0);
            end
            if (k == NK - 2) check({name, "_done_not_yet"}, 32'(o_done), 0);
        end
        model_run();
        check({name, "_done"}, 32'(o_done), 1);
        check({name, "_busy"}, 32'(o_busy), 0);
        check({name, "_pass"}, 32'(o_pass), 32'(e_mask == 0));
        check({name, "_perm_err"}, 32'(o_perm_err), 0);
        check({name, "_mask"}, 32'(o_err_mask), 32'(e_mask));
        check({name, "_cnt"}, 32'(o_err_cnt), 32'(e_cnt));
        check({name, "_sat_cnt"}, 32'(o_err_cnt_b), 32'((e_cnt > 15) ? 15 : e_cnt));
`ifdef BENES_CHK_FIRST_FAIL_EN
        check({name, "_ff_valid"}, 32'(o_ff_valid), 32'(e_ffv));
        check({name, "_ff_lane"}, 32'(o_ff_lane), 32'(e_fflane));
        check({name, "_ff_cycle"}, 32'(o_ff_cycle), 32'(e_ffcyc));
        check({name, "_ff_exp"}, 32'(o_ff_exp), 32'(e_ffexp));
        check({name, "_ff_act"}, 32'(o_ff_act), 32'(e_ffact));
`endif
    endtask

    initial begin
        int sl, sk;
        rst = 1'b1; i_start = 1'b0; i_perm = '0; i_port = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // identity, ideal counters, 3-cycle network delay
        set_identity(chk_p); set_identity(route_p); random_bases();
        run_stream("ident", 3, -1, 0, 0, 1'b0, -1);
        check("ident_cnt_zero", 32'(o_err_cnt), 0);

        // reversed routing, restart from DONE, starts during the run ignored
        set_reverse(chk_p); set_reverse(route_p); random_bases();
        run_stream("rev", 1, -1, 0, 0, 1'b1, -1);

        // reversed streams checked against identity: every lane wrong every cycle
        set_identity(chk_p);
        run_stream("rev_vs_id", 1, -1, 0, 0, 1'b0, -1);
        check("rev_vs_id_mask_ff", 32'(o_err_mask), 32'hFF);
        check("rev_vs_id_cnt_2048", 32'(o_err_cnt), 32'(SIZE * CC));

        // duplicate source: verdict two edges after start, no check phase
        @(negedge clk);
        chk_p = '{0, 0, 2, 3, 4, 5, 6, 7};
        i_start = 1'b1; i_perm = pack_chk();
        @(posedge clk); #1;
        check("dup_busy", 32'(o_busy), 1);
        check("dup_cleared_mask", 32'(o_err_mask), 0);
        @(negedge clk);
        i_start = 1'b0; i_perm = perm_vec_t'($urandom);
        @(posedge clk); #1;
        check("dup_perm_err", 32'(o_perm_err), 1);
        check("dup_done", 32'(o_done), 1);
        check("dup_pass", 32'(o_pass), 0);
        check("dup_busy_low", 32'(o_busy), 0);
        repeat (20) @(posedge clk);
        #1;
        check("dup_hold_done", 32'(o_done), 1);
        check("dup_hold_perm_err", 32'(o_perm_err), 1);
        check("dup_cnt", 32'(o_err_cnt), 0);

        // slip on lane 5 at check cycle 40
        set_identity(chk_p); set_identity(route_p); random_bases();
        run_stream("slip5", 2, 5, CHK0_K + 40, int'($urandom_range(255, 1)), 1'b0, -1);
        check("slip5_mask", 32'(o_err_mask), 32'h20);
        check("slip5_cnt", 32'(o_err_cnt), 1);

        // wrap: lane 0 passes FF->00, lane 7 passes 02->FE
        set_identity(chk_p); set_identity(route_p); random_bases();
        base[0] = 255 - LOCK_K;
        base[7] = 2 + 4 * LOCK_K;
        run_stream("wrap", 0, -1, 0, 0, 1'b0, -1);
        check("wrap_pass", 32'(o_pass), 1);

        // random permutations and slips
        for (int n = 0; n < 3; n++) begin
            set_shuffle(chk_p); route_p = chk_p; random_bases();
            sl = int'($urandom_range(SIZE - 1, 0));
            sk = int'($urandom_range(NK - 1, LOCK_K));
            run_stream("rand", int'($urandom_range(6, 0)), sl, sk,
                       int'($urandom_range(255, 1)), 1'b0, -1);
        end

        // reset in the middle of CHECK
        set_shuffle(chk_p); route_p = chk_p; random_bases();
        run_stream("midrst", 2, 3, 60, 7, 1'b0, 150);
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_busy", 32'(o_busy), 0);
        check("post_rst_done", 32'(o_done), 0);

        // clean run from IDLE after reset
        set_shuffle(chk_p); route_p = chk_p; random_bases();
        run_stream("after_rst", 4, -1, 0, 0, 1'b0, -1);
        check("after_rst_pass", 32'(o_pass), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
